// File: rtl/lane_rf_pkg.sv
// lane_rf_pkg: shared defaults, sweep state encoding and address-width helper
// for the lane register file.
package lane_rf_pkg;
    localparam int RF_LANES  = 16;
    localparam int RF_REGS   = 16;
    localparam int RF_WIDTH  = 32;
    localparam int RF_RPORTS = 2;

    typedef enum logic {RF_CLEAR, RF_IDLE} rf_state_t;

    function automatic int rf_aw(input int regs);
        return (regs > 1) ? $clog2(regs) : 1;
    endfunction
endpackage

// File: rtl/lane_rf_lane.sv
// lane_rf_lane: one lane's register storage with a shared write port, a clear
// port and RPORTS registered read ports with write-first forwarding.
module lane_rf_lane
    import lane_rf_pkg::*;
#(
    parameter int REGS   = RF_REGS,
    parameter int WIDTH  = RF_WIDTH,
    parameter int RPORTS = RF_RPORTS,
    parameter int AW     = rf_aw(REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic [AW-1:0]            caddr,
    input  logic                     we,
    input  logic [AW-1:0]            waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [RPORTS-1:0]        re,
    input  logic [RPORTS*AW-1:0]     raddr,
    output logic [RPORTS*WIDTH-1:0]  rdata
);
    localparam logic [AW:0] NREGS = (AW+1)'(REGS);

    logic [WIDTH-1:0] mem [REGS];

    always_ff @(posedge clk) begin
        if (clr)
            mem[caddr] <= '0;
        else if (we && {1'b0, waddr} < NREGS)
            mem[waddr] <= wdata;
    end

    // Out-of-range addresses read as zero; a same-cycle write wins over storage.
    always_ff @(posedge clk) begin
        for (int p = 0; p < RPORTS; p++) begin
            if (rst || !re[p] || {1'b0, raddr[p*AW +: AW]} >= NREGS)
                rdata[p*WIDTH +: WIDTH] <= '0;
            else
                rdata[p*WIDTH +: WIDTH] <= (we && waddr == raddr[p*AW +: AW]) ? wdata : mem[raddr[p*AW +: AW]];
        end
    end
endmodule

// File: rtl/lane_register_file.sv
// lane_register_file: per-lane SIMT vector register file with registered,
// forwarded reads and a clear sequencer that zeroes storage after reset or on request.
module lane_register_file
    import lane_rf_pkg::*;
#(
    parameter int LANES  = RF_LANES,
    parameter int REGS   = RF_REGS,
    parameter int WIDTH  = RF_WIDTH,
    parameter int RPORTS = RF_RPORTS,
    localparam int AW    = rf_aw(REGS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [LANES-1:0]               write_en,
    input  logic [AW-1:0]                  waddr,
    input  logic [LANES*WIDTH-1:0]         wdata,
    input  logic [RPORTS*LANES-1:0]        read_en,
    input  logic [RPORTS*AW-1:0]           raddr,
    output logic [RPORTS*LANES*WIDTH-1:0]  rdata,
    output logic [RPORTS-1:0]              rvalid,
    input  logic                           clear_req,
    output logic                           busy
);
    rf_state_t     state, state_n;
    logic [AW-1:0] cnt, cnt_n;
    logic          acc, clr, last;

    assign busy = rst || state == RF_CLEAR;
    assign acc  = !busy && !clear_req;
    assign clr  = !rst && state == RF_CLEAR;
    assign last = cnt == AW'(REGS - 1);

    always_comb begin
        state_n = (state == RF_CLEAR) ? (last ? RF_IDLE : RF_CLEAR) : (clear_req ? RF_CLEAR : RF_IDLE);
        cnt_n   = (state == RF_CLEAR && !last) ? cnt + 1'b1 : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RF_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < RPORTS; p++)
            rvalid[p] <= acc && |read_en[p*LANES +: LANES];
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [RPORTS-1:0]       re;
        logic [RPORTS*WIDTH-1:0] rd;
        for (genvar p = 0; p < RPORTS; p++) begin : g_port
            assign re[p] = acc && read_en[p*LANES+l];
            assign rdata[(p*LANES+l)*WIDTH +: WIDTH] = rd[p*WIDTH +: WIDTH];
        end
        lane_rf_lane #(.REGS(REGS), .WIDTH(WIDTH), .RPORTS(RPORTS), .AW(AW)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .clr   (clr),
            .caddr (cnt),
            .we    (acc && write_en[l]),
            .waddr (waddr),
            .wdata (wdata[l*WIDTH +: WIDTH]),
            .re    (re),
            .raddr (raddr),
            .rdata (rd)
        );
    end
endmodule

// File: tb/tb_lane_register_file.sv
// tb_lane_register_file: default and reduced (4 lanes, 12 regs, 8 bits, 3 ports)
// instances checked every cycle against an array-based model plus literal spot checks.
module tb_lane_register_file;
    logic clk = 0;
    always #5 clk = ~clk;

    logic rst_a, cr_a, busy_a;
    logic [15:0] we_a; logic [3:0] wa_a; logic [511:0] wd_a; logic [31:0] re_a; logic [7:0] ra_a;
    logic [1023:0] rd_a; logic [1:0] rv_a;
    logic rst_b, cr_b, busy_b;
    logic [3:0] we_b; logic [3:0] wa_b; logic [31:0] wd_b; logic [11:0] re_b; logic [11:0] ra_b;
    logic [95:0] rd_b; logic [2:0] rv_b;

    lane_register_file u_a (
        .clk(clk), .rst(rst_a), .write_en(we_a), .waddr(wa_a), .wdata(wd_a), .read_en(re_a),
        .raddr(ra_a), .rdata(rd_a), .rvalid(rv_a), .clear_req(cr_a), .busy(busy_a));
    lane_register_file #(.LANES(4), .REGS(12), .WIDTH(8), .RPORTS(3)) u_b (
        .clk(clk), .rst(rst_b), .write_en(we_b), .waddr(wa_b), .wdata(wd_b), .read_en(re_b),
        .raddr(ra_b), .rdata(rd_b), .rvalid(rv_b), .clear_req(cr_b), .busy(busy_b));

    localparam int NL [2] = '{16, 4};
    localparam int NR [2] = '{16, 12};
    localparam int NW [2] = '{32, 8};
    localparam int NP [2] = '{2, 3};

    logic [31:0]   mem [2][16][16];
    int            left [2] = '{16, 12};
    logic [1535:0] exp_rd [2];
    logic [2:0]    exp_rv [2];
    bit            started = 0;
    int            vectors = 0, errors = 0;

    task automatic check(input string nm, input logic [1535:0] act, input logic [1535:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock of the spec: reset rearms a full sweep, a sweep zeroes everything when it ends,
    // otherwise reads see old contents (or same-cycle write data) and then writes land.
    task automatic step(input int i, input logic r, input logic [15:0] we, input logic [3:0] wa,
                        input logic [511:0] wd, input logic [47:0] re, input logic [11:0] ra, input logic cr);
        logic [1535:0] rd; logic [2:0] rv; logic [31:0] msk, v; logic [3:0] a;
        rd = '0; rv = '0;
        msk = (NW[i] == 32) ? 32'hFFFF_FFFF : (32'd1 << NW[i]) - 32'd1;
        if (r) left[i] = NR[i];
        else if (left[i] > 0) begin
            left[i]--;
            if (left[i] == 0)
                for (int l = 0; l < 16; l++) for (int k = 0; k < 16; k++) mem[i][l][k] = '0;
        end else if (cr) left[i] = NR[i];
        else begin
            for (int p = 0; p < NP[i]; p++) begin
                a = ra[p*4 +: 4];
                for (int l = 0; l < NL[i]; l++) begin
                    if (!re[p*NL[i]+l]) continue;
                    rv[p] = 1'b1;
                    v = 32'(wd >> (l*NW[i])) & msk;
                    if (int'(a) >= NR[i]) v = '0;
                    else if (!(we[l] && wa == a)) v = mem[i][l][a];
                    rd |= 1536'(v) << ((p*NL[i]+l)*NW[i]);
                end
            end
            for (int l = 0; l < NL[i]; l++)
                if (we[l] && int'(wa) < NR[i]) mem[i][l][wa] = 32'(wd >> (l*NW[i])) & msk;
        end
        exp_rd[i] = rd; exp_rv[i] = rv;
    endtask

    always @(posedge clk) begin
        step(0, rst_a, we_a, wa_a, wd_a, 48'(re_a), 12'(ra_a), cr_a);
        step(1, rst_b, 16'(we_b), wa_b, 512'(wd_b), 48'(re_b), ra_b, cr_b);
        started = 1;
    end

    always @(negedge clk) if (started) begin
        check("busy_a", 1536'(busy_a), 1536'(rst_a || left[0] > 0));
        check("rvalid_a", 1536'(rv_a), 1536'(exp_rv[0]));
        check("rdata_a", 1536'(rd_a), exp_rd[0]);
        check("busy_b", 1536'(busy_b), 1536'(rst_b || left[1] > 0));
        check("rvalid_b", 1536'(rv_b), 1536'(exp_rv[1]));
        check("rdata_b", 1536'(rd_b), exp_rd[1]);
    end

    task automatic op_a(input logic [15:0] we, input logic [3:0] wa, input logic [511:0] wd,
                        input logic [31:0] re, input logic [7:0] ra, input logic cr);
        we_a = we; wa_a = wa; wd_a = wd; re_a = re; ra_a = ra; cr_a = cr;
        @(posedge clk); #1;
        we_a = '0; wa_a = '0; wd_a = '0; re_a = '0; ra_a = '0; cr_a = 0;
    endtask

    task automatic op_b(input logic [3:0] we, input logic [3:0] wa, input logic [31:0] wd,
                        input logic [11:0] re, input logic [11:0] ra, input logic cr);
        we_b = we; wa_b = wa; wd_b = wd; re_b = re; ra_b = ra; cr_b = cr;
        @(posedge clk); #1;
        we_b = '0; wa_b = '0; wd_b = '0; re_b = '0; ra_b = '0; cr_b = 0;
    endtask

    task automatic sweep_len(input int i, input int cr_at, output int n);
        n = 0;
        while ((i == 0 ? busy_a : busy_b) && n < 100) begin
            if (i == 0) cr_a = (n == cr_at); else cr_b = (n == cr_at);
            @(posedge clk); #1;
            n++;
        end
        cr_a = 0; cr_b = 0;
    endtask

    initial begin
        int n;
        logic [511:0] wd;
        logic [31:0] wdb;
        rst_a = 1; rst_b = 1;
        we_a = '0; wa_a = '0; wd_a = '0; re_a = '0; ra_a = '0; cr_a = 0;
        we_b = '0; wa_b = '0; wd_b = '0; re_b = '0; ra_b = '0; cr_b = 0;
        repeat (3) @(posedge clk);
        #1 rst_a = 0;
        sweep_len(0, -1, n);
        check("reset_sweep_len_a", 1536'(n), 1536'(16));
        for (int r = 0; r < 16; r++) op_a('0, '0, '0, '1, {4'(r), 4'(r)}, 0);
        check("cleared_rvalid_a", 1536'(rv_a), 1536'(2'b11));
        check("cleared_rdata_a", 1536'(rd_a), '0);

        for (int l = 0; l < 16; l++) wd[l*32 +: 32] = 32'hA500_0000 + 32'(l);
        op_a('1, 4'd7, wd, '0, '0, 0);
        op_a('0, '0, '0, 32'h0000_FFFF, 8'h07, 0);
        check("a5_p0_lane3", 1536'(rd_a[3*32 +: 32]), 1536'(32'hA500_0003));
        check("a5_p1_off", 1536'(rd_a[19*32 +: 32]), '0);
        op_a('0, '0, '0, 32'hFFFF_0000, 8'h70, 0);
        check("a5_p1_lane5", 1536'(rd_a[21*32 +: 32]), 1536'(32'hA500_0005));
        check("a5_p1_rvalid", 1536'(rv_a), 1536'(2'b10));
        op_a('0, '0, '0, '1, 8'h77, 0);
        check("a5_p0_lane15", 1536'(rd_a[15*32 +: 32]), 1536'(32'hA500_000F));
        check("a5_p1_lane0", 1536'(rd_a[16*32 +: 32]), 1536'(32'hA500_0000));

        for (int r = 0; r < 16; r++) begin
            for (int l = 0; l < 16; l++) wd[l*32 +: 32] = $urandom;
            op_a('1, 4'(r), wd, '0, '0, 0);
        end
        for (int r = 0; r < 16; r++) op_a('0, '0, '0, '1, {4'(15 - r), 4'(r)}, 0);

        op_a('1, 4'd3, {16{32'h1111_1111}}, '0, '0, 0);
        op_a(16'h00FF, 4'd3, {16{32'h2222_2222}}, '0, '0, 0);
        op_a('0, '0, '0, {16'h0F0F, 16'hFFFF}, 8'h33, 0);
        check("mask_p0_lane0", 1536'(rd_a[0 +: 32]), 1536'(32'h2222_2222));
        check("mask_p0_lane8", 1536'(rd_a[8*32 +: 32]), 1536'(32'h1111_1111));
        check("mask_p1_lane4", 1536'(rd_a[20*32 +: 32]), '0);
        check("mask_p1_lane8", 1536'(rd_a[24*32 +: 32]), 1536'(32'h1111_1111));

        op_a(16'h0004, 4'd5, {16{32'hDEAD_BEEF}}, '1, 8'h55, 0);
        check("fwd_p0_lane2", 1536'(rd_a[2*32 +: 32]), 1536'(32'hDEAD_BEEF));
        check("fwd_p1_lane2", 1536'(rd_a[18*32 +: 32]), 1536'(32'hDEAD_BEEF));
        op_a('0, '0, '0, '1, 8'h55, 0);

        op_a('1, 4'd9, {16{32'hCAFE_F00D}}, '1, 8'h99, 1);
        check("clrreq_rvalid", 1536'(rv_a), '0);
        sweep_len(0, -1, n);
        check("clrreq_sweep_len", 1536'(n), 1536'(16));
        for (int r = 0; r < 16; r++) op_a('0, '0, '0, '1, {4'(r), 4'(r)}, 0);
        op_a('0, '0, '0, '0, '0, 1);
        sweep_len(0, 4, n);
        check("clrreq_midsweep_len", 1536'(n), 1536'(16));

        rst_b = 0;
        sweep_len(1, -1, n);
        check("reset_sweep_len_b", 1536'(n), 1536'(12));
        for (int r = 0; r < 12; r++) begin
            for (int l = 0; l < 4; l++) wdb[l*8 +: 8] = 8'(r*16 + l);
            op_b(4'hF, 4'(r), wdb, '0, '0, 0);
        end
        op_b(4'hF, 4'd13, 32'hFFFF_FFFF, '0, '0, 0);
        op_b('0, '0, '0, 12'h00F, 12'h00D, 0);
        check("oor_rvalid", 1536'(rv_b), 1536'(3'b001));
        check("oor_rdata", 1536'(rd_b), '0);
        for (int r = 0; r < 12; r++) op_b('0, '0, '0, '1, {4'(r), 4'(11 - r), 4'(r)}, 0);
        op_b('0, '0, '0, '1, 12'h941, 0);
        check("3port_p0_lane2", 1536'(rd_b[2*8 +: 8]), 1536'(8'h12));
        check("3port_p1_lane0", 1536'(rd_b[4*8 +: 8]), 1536'(8'h40));
        check("3port_p2_lane3", 1536'(rd_b[11*8 +: 8]), 1536'(8'h93));
        check("3port_rvalid", 1536'(rv_b), 1536'(3'b111));
        op_b('0, '0, '0, '0, '0, 1);
        repeat (5) begin @(posedge clk); #1; end
        rst_b = 1;
        @(posedge clk); #1;
        rst_b = 0;
        sweep_len(1, -1, n);
        check("rst_midsweep_len_b", 1536'(n), 1536'(12));
        for (int r = 0; r < 12; r++) op_b('0, '0, '0, '1, {4'(r), 4'(r), 4'(r)}, 0);
        repeat (2) @(posedge clk);
        #1 $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
